// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1/8O1 with UART_RX_PARITY_EN defined), mid-bit sampling,
// one-entry valid/ready output buffer, sticky framing/overrun(/parity) error flags.
module uart_rx #(
    parameter int unsigned CYCLES_PER_BIT = 868,
    parameter int unsigned SYNC_STAGES    = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD     = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_break,
    output logic       err_frame,
    output logic       err_overrun,
`ifdef UART_RX_PARITY_EN
    output logic       err_parity,
`endif
    input  logic       err_clear
);

    localparam int unsigned CntW = $clog2(CYCLES_PER_BIT);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(CYCLES_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic                   par_bit_q;
    logic                   wait_high_q;
    logic                   rxs;
    logic                   parity_ok;

    assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
    assign parity_ok = ((^shift_q) ^ par_bit_q) == PARITY_ODD;
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sync_q      <= '1;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_bit_q   <= 1'b0;
            wait_high_q <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_break    <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            err_parity  <= 1'b0;
`endif
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
            rx_break <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            // Clears come first so a same-cycle error event below overrides them.
            if (err_clear) begin
                err_frame   <= 1'b0;
                err_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
                err_parity  <= 1'b0;
`endif
            end

            unique case (state_q)
                StIdle: begin
                    cnt_q     <= '0;
                    bit_idx_q <= 3'd0;
                    // After a bad stop bit, a held-low line must go high before re-arming.
                    if (rxs) wait_high_q <= 1'b0;
                    else if (!wait_high_q) state_q <= StStart;
                end
                StStart: begin
                    if (cnt_q == HalfCnt) begin
                        cnt_q   <= '0;
                        state_q <= rxs ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == FullCnt) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxs, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    if (cnt_q == FullCnt) begin
                        cnt_q     <= '0;
                        par_bit_q <= rxs;
                        state_q   <= StStop;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == FullCnt) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        if (rxs) begin
                            if (!parity_ok) begin
`ifdef UART_RX_PARITY_EN
                                err_parity <= 1'b1;
`endif
                            end else if (!rx_valid || rx_ready) begin
                                rx_data  <= shift_q;
                                rx_valid <= 1'b1;
                            end else begin
                                err_overrun <= 1'b1;
                            end
                        end else begin
                            err_frame   <= 1'b1;
                            wait_high_q <= 1'b1;
                            if (shift_q == 8'h00) rx_break <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the board-level `uart_rxd` pin; the counterpart to the transmit path driving `uart_txd`.
- Synchronises the asynchronous serial line, detects and validates start bits, and samples 8 data bits LSB-first at mid-bit.
- Checks the stop bit and presents each received byte on a valid/ready interface to the core.
- Reports framing and overrun errors as sticky flags.

Parameters:
- CYCLES_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 16..65535.
- SYNC_STAGES, 2, flip-flop stages on `uart_rxd` before use; legal range 2..4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- uart_rxd  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- rx_break  output  1  pulse: a complete frame of all zeros with stop=0 was seen.
- err_frame  output  1  sticky: stop bit sampled low.
- err_overrun  output  1  sticky: a new byte completed while the buffer was still full.
- err_clear  input  1  clears err_frame and err_overrun (and err_parity when enabled).

Behaviour:
- Reset: rx_data=0x00, rx_valid=0, rx_break=0, err_frame=0, err_overrun=0, FSM=IDLE, counters=0, synchroniser flops=1. A reset mid-frame abandons the frame; no partial byte is ever presented.
- Synchroniser: SYNC_STAGES flops reset to 1; `rxs` is the last stage. Pin-to-rxs latency is SYNC_STAGES cycles.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE: on rxs==0, go to START with bit counter cleared and cycle counter = 0.
- START: at cycle counter == CYCLES_PER_BIT/2 - 1 (integer division):
  - rxs==0: go to DATA with cycle counter = 0.
  - rxs==1: glitch; return to IDLE with no error.
- DATA: sample rxs when the cycle counter reaches CYCLES_PER_BIT-1, shift into bit[idx] (LSB first), reset the counter. After bit 7, go to PARITY (if enabled) or STOP.
- STOP: sample at CYCLES_PER_BIT-1, then return to IDLE on the same cycle.
  - rxs==1: frame good. Load rx_data and set rx_valid=1 on the following cycle.
  - rxs==0 and shift register == 0: rx_break=1 for one cycle and err_frame=1; no byte is presented.
  - rxs==0 otherwise: err_frame=1; byte discarded.
- After a stop-bit failure, the FSM waits in IDLE for rxs==1 before a new start is accepted. This prevents re-triggering on a held-low line.
- Output buffer, one entry:
  - rx_valid clears on the cycle after a handshake (rx_valid & rx_ready).
  - A good frame completing while rx_valid=1 and no handshake occurs on that cycle: err_overrun=1, the old rx_data is retained, the new byte is dropped.
  - Handshake and frame completion on the same cycle: the new byte loads, rx_valid stays 1, no overrun.
- err_clear: clears the flags on the next edge. If an error event occurs on the same cycle as err_clear, set wins.
- Cycle counter width: $clog2(CYCLES_PER_BIT). Both counters saturate-free and wrap only under FSM control.
- Nominal latency: rx_valid rises at most CYCLES_PER_BIT/2 + SYNC_STAGES + 2 cycles after the mid-point of the stop bit on the pin.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state after DATA, sampled like a data bit.
  - Adds parameter PARITY_ODD (default 0 = even) and output `err_parity` (1 bit, sticky, reset 0, cleared by err_clear).
  - On mismatch: err_parity=1 and the byte is discarded even if the stop bit is good.
  - Frame length is 11 bits.
- Undefined: no PARITY state, no err_parity port, 10-bit frames. Behaviour is otherwise identical.

Test Plan:
- CYCLES_PER_BIT=16: send 0xA5 with a good stop bit, rx_ready=1 -> rx_data=0xA5 with a single-cycle rx_valid pulse; err_frame=0, err_overrun=0.
- Send 0x3C, hold rx_ready=0, then send 0xC3 -> rx_data stays 0x3C, err_overrun=1. After rx_ready=1 and err_clear -> rx_valid=0, err_overrun=0.
- Send 0x55 with the stop bit driven low -> no rx_valid, err_frame=1. Line returns high, then send 0x12 -> rx_data=0x12 is received normally.
- Low glitch of 5 cycles (< CYCLES_PER_BIT/2) on an idle line -> FSM back in IDLE; no rx_valid, no errors.
- Hold the line low for 12 bit times -> rx_break pulses once and err_frame=1. Raise the line, then send 0xFF -> rx_data=0xFF.
- Assert reset mid-DATA of 0x81 -> all outputs at reset values, no byte presented. Next frame 0x7E is received correctly.
- Parity build (UART_RX_PARITY_EN): 0x01 with even parity bit 0 -> err_parity=1 and byte dropped; with parity bit 1 -> rx_data=0x01.
